fifo_rd_stream: RTL and testbench

//  Read-side adapter that drains async_fifo in the rd_clk domain and presents an
//  AXI-Stream style valid/ready master with burst framing (m_last every BURST_LEN beats).

---
 rtl/fifo_rd_stream.sv | 92 +++++++++
 tb/tb_fifo_rd_stream.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: drains a 1-cycle-latency FIFO into a valid/ready stream with
// burst framing, using a 2-entry skid buffer so the stream runs at one beat per cycle.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 64,
   parameter int BURST_LEN  = 256
) (
   input  logic                  rd_clk,
   input  logic                  global_rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  burst_done
);

   localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   logic [1:0]            count;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] tail;
   logic [CNT_W-1:0]      beat_cnt;
   logic                  pop;
   logic [1:0]            occ;

   assign pop     = m_valid & m_ready;
   assign occ     = count + {1'b0, inflight};
   assign m_valid = (count != 2'd0);
   assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

   // Combinational through m_ready: a slot freed by this cycle's pop is reusable at once.
   assign fifo_rd_en = global_rst_n & ~fifo_empty & ((occ - {1'b0, pop}) < 2'd2);

   // NOTE: sequential state is updated with non-blocking assignments only, so every
   // branch below sees the pre-edge values of count, m_data and tail.
   always_ff @(posedge rd_clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         inflight <= 1'b0;
      end else begin
         inflight <= fifo_rd_en;
      end
   end

   // m_data is the buffer head; tail holds the second entry when count == 2.
   // NOTE: both skid entries are reset so m_data reads 0 out of reset; with only two
   // entries this costs nothing and keeps the stream output deterministic.
   always_ff @(posedge rd_clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         count  <= 2'd0;
         m_data <= '0;
         tail   <= '0;
      end else begin
         unique case ({inflight, pop})
            2'b10: begin
               if (count == 2'd0) m_data <= fifo_dout;
               else               tail   <= fifo_dout;
               count <= count + 2'd1;
            end
            2'b01: begin
               if (count == 2'd2) m_data <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  m_data <= fifo_dout;
               end else begin
                  m_data <= tail;
                  tail   <= fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge rd_clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         beat_cnt   <= '0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= pop & m_last;
         if (pop) begin
            if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
            else                       beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream (BURST_LEN=4) driving it from a behavioural
// 1-cycle-latency FIFO preloaded with word i = i.
module tb_fifo_rd_stream;

   localparam int DW = 16;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          global_rst_n;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_dout;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          burst_done;

   logic [DW-1:0] fifo_mem [0:1023];
   int            rd_ptr;
   int            wr_level;
   int            exp_idx;
   int            checks = 0;
   int            errors = 0;

   fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .rd_clk       (clk),
      .global_rst_n (global_rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_dout    (fifo_dout),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .burst_done   (burst_done)
   );

   always #5 clk = ~clk;

   // Upstream FIFO model, reset by the same global_rst_n.
   assign fifo_empty = (rd_ptr >= wr_level);
   always @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         rd_ptr <= 0;
      end else if (fifo_rd_en) begin
         fifo_dout <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs the sink for n beats with m_ready high ready_pct% of cycles, checking order,
   // framing, hold-while-stalled, burst_done timing and read throttling.
   task automatic drain(input int n, input int ready_pct, input string tag);
      int            got = 0;
      int            cyc = 0;
      int            occ_v;
      logic          pend = 1'b0;
      logic [DW-1:0] pend_data = '0;
      logic          prev_last_pop = 1'b0;
      logic          pop;
      while (got < n && cyc < n * 8 + 50) begin
         @(negedge clk);
         m_ready = ($urandom_range(99) < ready_pct);
         #1;
         check({tag, "_burst_done"}, burst_done, prev_last_pop);
         if (pend) check({tag, "_hold"}, {m_valid, m_data}, {1'b1, pend_data});
         pop   = m_valid & m_ready;
         occ_v = int'(dut.count) + int'(dut.inflight);
         check({tag, "_count_le2"}, dut.count <= 2, 1);
         if (occ_v - int'(pop) == 2) check({tag, "_no_read_full"}, fifo_rd_en, 0);
         if (pop) begin
            check({tag, "_data"}, m_data, exp_idx);
            check({tag, "_last"}, m_last, (exp_idx % BL) == BL - 1);
            exp_idx++;
            got++;
         end
         pend          = m_valid & ~m_ready;
         pend_data     = m_data;
         prev_last_pop = pop & m_last;
         cyc++;
      end
      check({tag, "_beats"}, got, n);
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < 1024; i++) fifo_mem[i] = DW'(i);
      global_rst_n = 1'b1;
      m_ready      = 1'b0;
      wr_level     = 10;
      exp_idx      = 0;
      #2 global_rst_n = 1'b0;

      // 1: outputs quiet in reset even though the FIFO holds data
      repeat (2) @(negedge clk);
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_last", m_last, 0);
      check("rst_burst_done", burst_done, 0);

      // 2+4: 10 words back-to-back, m_last on words 3 and 7
      @(negedge clk);
      m_ready      = 1'b1;
      global_rst_n = 1'b1;
      #1;
      check("t2_rd_en_first", fifo_rd_en, 1);
      @(negedge clk);
      check("t2_latency_valid", m_valid, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t2_valid", m_valid, 1);
         check("t2_data", m_data, i);
         check("t2_last", m_last, (i % BL) == BL - 1);
         check("t2_burst_done", burst_done, (i > 0) && ((i - 1) % BL == BL - 1));
      end
      @(negedge clk);
      check("t2_drained", m_valid, 0);
      check("t2_burst_done_end", burst_done, 0);
      check("t2_beat_cnt", dut.beat_cnt, 2);

      // 5: FIFO runs dry after 5 words, then refills; burst phase continues
      global_rst_n = 1'b0;
      @(negedge clk);
      wr_level     = 5;
      exp_idx      = 0;
      global_rst_n = 1'b1;
      drain(5, 100, "t5a");
      repeat (3) begin
         @(negedge clk);
         check("t5_gap_valid", m_valid, 0);
         check("t5_gap_rd_en", fifo_rd_en, 0);
      end
      wr_level = 10;
      drain(5, 100, "t5b");

      // 3: 1000 words with random backpressure
      global_rst_n = 1'b0;
      @(negedge clk);
      wr_level     = 1000;
      exp_idx      = 0;
      global_rst_n = 1'b1;
      drain(1000, 50, "t3");

      // 6: stall until the buffer is full, reset mid-operation
      global_rst_n = 1'b0;
      @(negedge clk);
      wr_level     = 10;
      exp_idx      = 0;
      global_rst_n = 1'b1;
      drain(2, 100, "t6a");
      @(negedge clk);
      m_ready = 1'b0;
      seen    = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (dut.count == 2) seen = 1'b1;
      end
      check("t6_full", seen, 1);
      check("t6_stall_data", m_data, 2);
      #2 global_rst_n = 1'b0;
      #1;
      check("t6_rst_valid", m_valid, 0);
      check("t6_rst_data", m_data, 0);
      check("t6_rst_last", m_last, 0);
      check("t6_rst_burst_done", burst_done, 0);
      check("t6_rst_rd_en", fifo_rd_en, 0);
      @(negedge clk);
      global_rst_n = 1'b1;
      exp_idx      = 0;
      #1;
      check("t6_beat_cnt", dut.beat_cnt, 0);
      drain(6, 100, "t6b");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
